// File: rtl/axi3_rd_slave_mem.sv
// AXI3 read-channel slave serving FIXED/INCR/WRAP bursts from a word-addressed
// synchronous memory; one outstanding burst, illegal requests answered with SLVERR.
module axi3_rd_slave_mem #(
    parameter int unsigned BUS_WIDTH      = 4,
    parameter int unsigned MEM_ADDR_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [BUS_WIDTH-1:0]      arid,
    input  logic [31:0]               araddr,
    input  logic [3:0]                arlen,
    input  logic [2:0]                arsize,
    input  logic [1:0]                arburst,
    input  logic [1:0]                arlock,
    input  logic [3:0]                arcache,
    input  logic [2:0]                arprot,
    input  logic                      arvalid,
    output logic                      arready,
    input  logic                      rready,
    output logic [BUS_WIDTH-1:0]      rid,
    output logic [31:0]               rdata,
    output logic [1:0]                rresp,
    output logic                      rlast,
    output logic                      rvalid,
    output logic                      mem_rd,
    output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
    input  logic [31:0]               mem_rddata
);
    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_SEND} state_t;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    state_t                    r_state, w_state_nxt;
    logic [BUS_WIDTH-1:0]      r_id, w_id_nxt;
    logic [31:0]               r_addr, w_addr_nxt;
    logic [31:0]               r_start, w_start_nxt;
    logic [3:0]                r_len, w_len_nxt;
    logic [3:0]                r_cnt, w_cnt_nxt;
    logic [2:0]                r_size, w_size_nxt;
    logic [1:0]                r_burst, w_burst_nxt;
    logic                      r_err, w_err_nxt;
    logic                      r_arready, r_rvalid, r_rlast, r_mem_rd;
    logic [1:0]                r_rresp;
    logic [MEM_ADDR_WIDTH-1:0] r_mem_addr;
    logic                      w_unused_sideband;

    assign w_unused_sideband = ^{arlock, arcache, arprot};

    // Address of the beat following addr for the latched burst parameters.
    function automatic logic [31:0] f_next_addr(
        input logic [31:0] addr,
        input logic [31:0] start,
        input logic [3:0]  len,
        input logic [2:0]  size,
        input logic [1:0]  burst
    );
        logic [31:0] sz;
        logic [31:0] span;
        logic [31:0] base;
        logic        wrap_ok;
        sz      = 32'(1) << size;
        span    = (32'(len) + 32'd1) << size;
        base    = start & ~(span - 32'd1);
        wrap_ok = (len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15);
        if (burst == BURST_FIXED) begin
            return addr;
        end else if ((burst == BURST_WRAP) && wrap_ok) begin
            return base + ((addr + sz - base) & (span - 32'd1));
        end
        return (addr & ~(sz - 32'd1)) + sz;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_id       <= '0;
            r_addr     <= '0;
            r_start    <= '0;
            r_len      <= '0;
            r_cnt      <= '0;
            r_size     <= '0;
            r_burst    <= '0;
            r_err      <= 1'b0;
            r_arready  <= 1'b1;
            r_rvalid   <= 1'b0;
            r_rlast    <= 1'b0;
            r_rresp    <= RESP_OKAY;
            r_mem_rd   <= 1'b0;
            r_mem_addr <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_id       <= w_id_nxt;
            r_addr     <= w_addr_nxt;
            r_start    <= w_start_nxt;
            r_len      <= w_len_nxt;
            r_cnt      <= w_cnt_nxt;
            r_size     <= w_size_nxt;
            r_burst    <= w_burst_nxt;
            r_err      <= w_err_nxt;
            r_arready  <= (w_state_nxt == S_IDLE);
            r_rvalid   <= (w_state_nxt == S_SEND);
            r_rlast    <= (w_state_nxt == S_SEND) && (w_cnt_nxt == 4'd0);
            r_rresp    <= ((w_state_nxt == S_SEND) && w_err_nxt) ? RESP_SLVERR : RESP_OKAY;
            r_mem_rd   <= (w_state_nxt == S_FETCH);
            if (w_state_nxt == S_FETCH) begin
                r_mem_addr <= w_addr_nxt[MEM_ADDR_WIDTH+1:2];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_id_nxt    = r_id;
        w_addr_nxt  = r_addr;
        w_start_nxt = r_start;
        w_len_nxt   = r_len;
        w_cnt_nxt   = r_cnt;
        w_size_nxt  = r_size;
        w_burst_nxt = r_burst;
        w_err_nxt   = r_err;
        case (r_state)
            S_IDLE: begin
                if (arvalid) begin
                    w_id_nxt    = arid;
                    w_addr_nxt  = araddr;
                    w_start_nxt = araddr;
                    w_len_nxt   = arlen;
                    w_cnt_nxt   = arlen;
                    w_size_nxt  = arsize;
                    w_burst_nxt = arburst;
                    w_err_nxt   = (arburst == 2'b11) || (arsize > 3'd2);
                    w_state_nxt = w_err_nxt ? S_SEND : S_FETCH;
                end
            end
            S_FETCH: w_state_nxt = S_SEND;
            S_SEND: begin
                if (rready) begin
                    if (r_cnt == 4'd0) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_cnt_nxt   = r_cnt - 4'd1;
                        w_addr_nxt  = f_next_addr(r_addr, r_start, r_len, r_size, r_burst);
                        w_state_nxt = r_err ? S_SEND : S_FETCH;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign arready  = r_arready;
    assign rvalid   = r_rvalid;
    assign rlast    = r_rlast;
    assign rresp    = r_rresp;
    assign rid      = r_id;
    assign mem_rd   = r_mem_rd;
    assign mem_addr = r_mem_addr;
    // Memory output is held between reads, so beat data stays stable under stalls.
    assign rdata    = r_err ? 32'd0 : mem_rddata;

endmodule

// File: tb/tb_axi3_rd_slave_mem.sv
// Randomized bench for axi3_rd_slave_mem against a closed-form burst address model.
module tb_axi3_rd_slave_mem;
    logic        clk;
    logic        rst;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [3:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [1:0]  arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic        rready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        mem_rd;
    logic [15:0] mem_addr;
    logic [31:0] mem_rddata;

    logic [31:0] mem [0:65535];
    int          n_checks;
    int          n_errors;

    axi3_rd_slave_mem #(.BUS_WIDTH(4), .MEM_ADDR_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .arid(arid), .araddr(araddr), .arlen(arlen),
        .arsize(arsize), .arburst(arburst), .arlock(arlock), .arcache(arcache),
        .arprot(arprot), .arvalid(arvalid), .arready(arready), .rready(rready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rddata(mem_rddata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous memory: data appears the cycle after mem_rd and is held.
    always @(posedge clk) begin
        if (mem_rd) mem_rddata <= mem[mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Byte address of beat i, in closed form.
    function automatic logic [31:0] beat_addr(input logic [31:0] a, input int i,
                                              input logic [3:0] len, input logic [2:0] size,
                                              input logic [1:0] burst);
        logic [31:0] sz;
        logic [31:0] span;
        logic [31:0] base;
        sz = 32'(1) << size;
        if (i == 0 || burst == 2'b00) return a;
        if (burst == 2'b10 && (len == 4'd1 || len == 4'd3 || len == 4'd7 || len == 4'd15)) begin
            span = (32'(len) + 32'd1) * sz;
            base = a - (a % span);
            return base + ((a - base + 32'(i) * sz) % span);
        end
        return (a - (a % sz)) + 32'(i) * sz;
    endfunction

    // mode: 0 rready always 1, 1 pattern 1,0,0 repeating, 2 random.
    task automatic run_burst(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                             input logic [2:0] size, input logic [1:0] burst, input int mode);
        int          cyc;
        int          beat;
        int          nfetch;
        int          first_rv;
        int          last_hs;
        int          k;
        logic        stalled;
        logic        legal;
        logic [31:0] ea;
        logic [31:0] exp_data;
        legal = (burst != 2'b11) && (size <= 3'd2);
        @(negedge clk);
        arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst;
        arlock = 2'($urandom); arcache = 4'($urandom); arprot = 3'($urandom);
        arvalid = 1'b1;
        cyc = 0;
        while (!arready && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        chk("ar_ready_wait", 32'(arready), 32'd1);
        @(negedge clk);
        arvalid = 1'b0;
        cyc = 1; beat = 0; nfetch = 0; first_rv = 0; last_hs = 0; k = 0; stalled = 1'b0;
        while (beat <= int'(len) && cyc < 300) begin
            if (!legal) begin
                chk("err_no_mem_rd", 32'(mem_rd), 32'd0);
            end else if (mem_rd) begin
                ea = beat_addr(addr, nfetch, len, size, burst);
                chk("mem_addr", 32'(mem_addr), 32'(ea[17:2]));
                nfetch++;
            end
            chk("arready_busy", 32'(arready), 32'd0);
            if (stalled) chk("stall_rvalid", 32'(rvalid), 32'd1);
            if (rvalid) begin
                if (first_rv == 0) first_rv = cyc;
                ea = beat_addr(addr, beat, len, size, burst);
                exp_data = legal ? mem[ea[17:2]] : 32'd0;
                chk("rdata", rdata, exp_data);
                chk("rresp", 32'(rresp), legal ? 32'd0 : 32'd2);
                chk("rlast", 32'(rlast), 32'(beat == int'(len)));
                chk("rid", 32'(rid), 32'(id));
            end
            case (mode)
                0:       rready = 1'b1;
                1:       rready = (k % 3 == 0);
                default: rready = 1'($urandom_range(0, 1));
            endcase
            k++;
            stalled = rvalid && !rready;
            if (rvalid && rready) begin
                beat++;
                if (beat > int'(len)) last_hs = cyc;
            end
            @(negedge clk);
            cyc++;
        end
        rready = 1'b0;
        chk("beats_done", 32'(beat), 32'(len) + 32'd1);
        chk("fetch_count", 32'(nfetch), legal ? 32'(len) + 32'd1 : 32'd0);
        chk("first_rvalid_lat", 32'(first_rv), legal ? 32'd2 : 32'd1);
        if (mode == 0)
            chk("last_hs_lat", 32'(last_hs), legal ? 32'(2 * (int'(len) + 1)) : 32'(int'(len) + 1));
        chk("idle_arready", 32'(arready), 32'd1);
        chk("idle_rvalid", 32'(rvalid), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          cyc;
        int          beat;
        logic [1:0]  b;
        logic [2:0]  s;
        int          r;
        n_checks = 0;
        n_errors = 0;
        for (int i = 0; i < 65536; i++) mem[i] = $urandom;
        mem[16'h0040] = 32'hDEADBEEF;
        rst = 1'b1; arvalid = 1'b0; rready = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0;
        arlock = '0; arcache = '0; arprot = '0;
        repeat (3) @(negedge clk);
        chk("rst_arready", 32'(arready), 32'd1);
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        chk("rst_rlast", 32'(rlast), 32'd0);
        chk("rst_mem_rd", 32'(mem_rd), 32'd0);
        chk("rst_rresp", 32'(rresp), 32'd0);
        chk("rst_rid", 32'(rid), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        rst = 1'b0;

        run_burst(4'd5, 32'h100, 4'd0, 3'd2, 2'b01, 0);
        run_burst(4'd3, 32'h200, 4'd3, 3'd2, 2'b01, 1);
        run_burst(4'd7, 32'h108, 4'd3, 3'd2, 2'b10, 0);
        run_burst(4'd1, 32'h010, 4'd2, 3'd2, 2'b00, 0);
        run_burst(4'd9, 32'h400, 4'd2, 3'd2, 2'b11, 0);
        run_burst(4'd2, 32'h400, 4'd1, 3'd3, 2'b01, 2);
        run_burst(4'd4, 32'hFFFF_FFF6, 4'd4, 3'd1, 2'b01, 0);

        // Reset during beat 2 of an 8-beat burst.
        @(negedge clk);
        arid = 4'd6; araddr = 32'h300; arlen = 4'd7; arsize = 3'd2; arburst = 2'b01;
        arvalid = 1'b1;
        @(negedge clk);
        arvalid = 1'b0;
        rready = 1'b1;
        cyc = 0; beat = 0;
        while (cyc < 40 && !(rvalid && beat == 1)) begin
            if (rvalid) beat++;
            @(negedge clk);
            cyc++;
        end
        chk("rst_mid_reach_beat2", 32'(beat), 32'd1);
        rst = 1'b1; rready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_rvalid", 32'(rvalid), 32'd0);
        chk("rst_mid_arready", 32'(arready), 32'd1);
        repeat (4) begin
            @(negedge clk);
            chk("rst_mid_no_mem_rd", 32'(mem_rd), 32'd0);
            chk("rst_mid_no_rvalid", 32'(rvalid), 32'd0);
        end
        run_burst(4'd8, 32'h500, 4'd3, 3'd2, 2'b01, 0);

        for (int n = 0; n < 40; n++) begin
            r = $urandom_range(0, 9);
            b = (r == 0) ? 2'b11 : 2'(r % 3);
            s = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            run_burst(4'($urandom), $urandom, 4'($urandom), s, b, $urandom_range(0, 2));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/axi3_rd_slave_mem.md
# axi3_rd_slave_mem

AXI3 read-channel responder that serves bursts from a word-addressed synchronous memory. It is the slave-side counterpart of the `axi3_rd_if` master used by the instruction cache. It sits in the simulation SoC and the boot-ROM path, accepting one AR request at a time and returning up to 16 beats on R with full `rready` backpressure.

## Interface
Parameters:
- `BUS_WIDTH`, 4: ID width (`arid`/`rid`).
- `MEM_ADDR_WIDTH`, 16: word-address width of the backing memory.

Ports: clock and reset are `clk`/`rst`. `rst` is synchronous and active-high, on a single clock `clk`.
- `clk`  in  1  clock.
- `rst`  in  1  synchronous active-high reset.
- `arid`  in  BUS_WIDTH  request ID.
- `araddr`  in  32  byte start address.
- `arlen`  in  4  beats minus 1.
- `arsize`  in  3  log2 bytes per beat.
- `arburst`  in  2  burst type: 00 FIXED, 01 INCR, 10 WRAP, 11 reserved.
- `arlock`, `arcache`, `arprot`  in  2/4/3  accepted and ignored.
- `arvalid`  in  1  AR valid.
- `arready`  out  1  AR ready.
- `rready`  in  1  R ready.
- `rid`  out  BUS_WIDTH  echoes latched `arid`.
- `rdata`  out  32  beat data.
- `rresp`  out  2  00 OKAY, 10 SLVERR.
- `rlast`  out  1  final beat.
- `rvalid`  out  1  R valid.
- `mem_rd`  out  1  memory read strobe.
- `mem_addr`  out  MEM_ADDR_WIDTH  word address = `addr[MEM_ADDR_WIDTH+1:2]`.
- `mem_rddata`  in  32  memory data.
  - Valid the cycle after `mem_rd`.
  - Held until the next `mem_rd`.

## Operation
- FSM states: IDLE, FETCH, SEND.
- IDLE:
  - `arready`=1.
  - On `arvalid`, latch `arid`, `araddr`, `arlen`, `arsize`, `arburst`.
  - Set beat counter `cnt`=`arlen`.
  - Next state is FETCH if the request is legal, else SEND with the error flag set.
- Legal request: `arburst`≠11 and `arsize`≤2. Otherwise the error flag is set.
  - Every beat returns `rresp`=10 and `rdata`=0.
  - No `mem_rd` is issued for the burst.
  - The burst still returns `arlen`+1 beats with correct `rlast`.
- FETCH: `mem_rd`=1 with `mem_addr` from the current `addr`, for exactly one cycle. Next state is SEND.
- SEND:
  - `rvalid`=1, `rdata`=`mem_rddata`, `rlast`=(`cnt`==0).
  - Hold until `rready`. On handshake:
    - if `rlast`, go to IDLE;
    - else decrement `cnt`, advance `addr`, go to FETCH (or SEND directly when the error flag is set).
- Address advance, with size = 1<<`arsize`:
  - FIXED: `addr` unchanged.
  - INCR: `addr` = (`addr` & ~(size−1)) + size. An unaligned start realigns from beat 2 on. 32-bit wrap-around is allowed.
  - WRAP: boundary span = (`arlen`+1)·size.
    - Next address = base + ((`addr`+size−base) mod span), with base = `araddr` & ~(span−1).
    - A WRAP with `arlen` not in {1,3,7,15} is treated as INCR.
- `rid` is held stable at the latched ID for the whole burst.
- Only one outstanding burst. `arready`=0 from the handshake cycle+1 until the cycle after the last R handshake.

## Timing
- Reset values:
  - `arready`=1 (FSM in IDLE).
  - `rvalid`=0, `rlast`=0, `mem_rd`=0.
  - `rresp`=00, `rid`=0, `mem_addr`=0, `cnt`=0.
- Reset mid-burst:
  - Next cycle is IDLE with `rvalid`=0.
  - The remaining beats are discarded and no further `mem_rd` is issued.
- Latency:
  - AR handshake at cycle T gives `mem_rd` at T+1 and first `rvalid` at T+2.
  - With `rready` held 1, beats arrive every 2 cycles. An N-beat burst ends (last handshake) at T+2N.
  - Error bursts: first `rvalid` at T+1, then one beat per cycle.
- `rvalid`, `rdata`, `rresp`, `rlast`, `rid` remain stable while `rvalid`=1 and `rready`=0.
- Simultaneous last-beat handshake and new `arvalid`: the new request is not accepted that cycle. `arready` rises the next cycle.
- `arvalid` is ignored outside IDLE; the master must hold it per AXI.

## Test plan
- INCR single beat:
  - Stimulus: `araddr`=0x100, `arlen`=0, `arsize`=2, `arid`=5, mem[0x40]=0xDEADBEEF.
  - Required: `mem_addr`=0x40 at T+1; `rdata`=0xDEADBEEF, `rlast`=1, `rid`=5, `rresp`=00 at T+2.
- INCR 4-beat burst with `rready` toggled 1,0,0,1...:
  - Stimulus: `araddr`=0x200.
  - Required: `mem_addr` 0x80,0x81,0x82,0x83; R outputs held stable during stalls; `rlast` only on beat 4.
- WRAP 4-beat:
  - Stimulus: `araddr`=0x108, `arsize`=2.
  - Required: addresses 0x108,0x10C,0x100,0x104 (`mem_addr` 0x42,0x43,0x40,0x41).
- FIXED 3-beat, `araddr`=0x10 -> `mem_addr`=0x4 on all three beats.
- Errors:
  - `arburst`=11, `arlen`=2 -> 3 beats with `rresp`=10, `rdata`=0, no `mem_rd`.
  - `arsize`=3 -> same error response.
- `rst` pulsed during beat 2 of an 8-beat burst:
  - Required: `rvalid`=0 and `arready`=1 the cycle after reset.
  - A new request is then served correctly from T+2.
